// File: rtl/mips_pipeline_ctrl.sv
// Run-control sequencer for the pipelined MIPS core: latch enables, PC reset,
// program erase, run/step/halt/drain modes and a saturating cycle counter.
// Optional breakpoint support: define MIPS_PIPE_CTRL_BREAKPOINT_EN.
module mips_pipeline_ctrl #(
  parameter int NUM_LATCHS  = 5,
  parameter int TAM_DATA    = 32,
  parameter int CYCLE_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [2:0]             i_cmd,
  output logic                   o_cmd_ready,
  output logic                   o_cmd_err,
  input  logic                   i_is_end,
  input  logic [TAM_DATA-1:0]    i_pc_value,
`ifdef MIPS_PIPE_CTRL_BREAKPOINT_EN
  input  logic                   i_bp_valid,
  input  logic [TAM_DATA-1:0]    i_bp_addr,
`endif
  output logic [NUM_LATCHS-1:0]  o_latches_en,
  output logic                   o_pc_reset,
  output logic                   o_borrar_programa,
  output logic [2:0]             o_state,
  output logic [CYCLE_CNT_W-1:0] o_cycle_count,
  output logic                   o_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4,
    S_DONE   = 3'd5,
    S_CLEAR  = 3'd6
  } state_e;

  localparam logic [2:0] CMD_RUN      = 3'd1;
  localparam logic [2:0] CMD_STEP     = 3'd2;
  localparam logic [2:0] CMD_HALT     = 3'd3;
  localparam logic [2:0] CMD_CLEAR    = 3'd4;
  localparam logic [2:0] CMD_RESET_PC = 3'd5;

  localparam int                   DRAIN_W    = $clog2(NUM_LATCHS + 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_INIT = DRAIN_W'(NUM_LATCHS - 1);
  localparam logic [NUM_LATCHS-1:0] LAT_ALL   = '1;
  localparam logic [NUM_LATCHS-1:0] LAT_DRAIN = LAT_ALL >> 1;

  state_e                   state_q, state_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  logic                     ready_q, err_q, pc_reset_q, borrar_q, done_q;
  logic [NUM_LATCHS-1:0]    lat_q, lat_d;
  logic [CYCLE_CNT_W-1:0]   cnt_q;
  logic                     accept, err_d, pc_rst_cmd, clr_cnt, bp_hit;

  assign accept = i_cmd_valid && ready_q;

`ifdef MIPS_PIPE_CTRL_BREAKPOINT_EN
  // The first RUN cycle after a resume from HALTED must not re-trigger the
  // breakpoint the core is still sitting on.
  logic bp_skip_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) bp_skip_q <= 1'b0;
    else         bp_skip_q <= (state_q == S_HALTED) && (state_d == S_RUN);
  end
  assign bp_hit = i_bp_valid && (i_pc_value == i_bp_addr) && !bp_skip_q;
`else
  logic unused_pc;
  assign unused_pc = ^i_pc_value;
  assign bp_hit    = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    err_d      = 1'b0;
    pc_rst_cmd = 1'b0;
    clr_cnt    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (accept) begin
          unique case (i_cmd)
            CMD_RUN:      state_d = S_RUN;
            CMD_STEP:     state_d = S_STEP;
            CMD_CLEAR:    begin state_d = S_CLEAR; clr_cnt = 1'b1; end
            CMD_RESET_PC: begin state_d = S_IDLE; pc_rst_cmd = 1'b1; clr_cnt = 1'b1; end
            default:      err_d = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        if (accept && i_cmd == CMD_HALT) begin
          state_d = S_HALTED;
        end else begin
          err_d = accept;
          if (bp_hit) begin
            state_d = S_HALTED;
          end else if (i_is_end) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      S_STEP: begin
        if (i_is_end) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          state_d = S_HALTED;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q <= DRAIN_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (accept) begin
          unique case (i_cmd)
            CMD_CLEAR:    begin state_d = S_CLEAR; clr_cnt = 1'b1; end
            CMD_RESET_PC: begin state_d = S_IDLE; pc_rst_cmd = 1'b1; clr_cnt = 1'b1; end
            default:      err_d = 1'b1;
          endcase
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_RUN, S_STEP: lat_d = LAT_ALL;
      S_DRAIN:       lat_d = LAT_DRAIN;
      default:       lat_d = '0;
    endcase
  end

  // Outputs are registered from the next-state decode so they change together
  // with o_state on the edge that samples the command.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      drain_q    <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      pc_reset_q <= 1'b0;
      borrar_q   <= 1'b0;
      done_q     <= 1'b0;
      lat_q      <= '0;
      cnt_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge values of its neighbours.
      state_q    <= state_d;
      drain_q    <= drain_d;
      ready_q    <= state_d inside {S_IDLE, S_RUN, S_HALTED, S_DONE};
      err_q      <= err_d;
      pc_reset_q <= pc_rst_cmd || (state_d == S_CLEAR);
      borrar_q   <= (state_d == S_CLEAR);
      done_q     <= (state_d == S_DONE) && (state_q != S_DONE);
      lat_q      <= lat_d;
      if (clr_cnt)                          cnt_q <= '0;
      else if (|lat_q && (cnt_q != '1))     cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_cmd_ready       = ready_q;
  assign o_cmd_err         = err_q;
  assign o_latches_en      = lat_q;
  assign o_pc_reset        = pc_reset_q;
  assign o_borrar_programa = borrar_q;
  assign o_state           = state_q;
  assign o_cycle_count     = cnt_q;
  assign o_done            = done_q;

endmodule
